rf_writeback_arbiter: RTL and testbench

//   Shares the single register-file write port between the in-order pipeline writeback

---
 rtl/rf_writeback_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: shares the register-file write port between the in-order
// pipeline writeback stage and an out-of-order long-latency unit. Long-unit results
// are buffered in a small FIFO; the pipeline has priority, and a starvation counter
// forces the long unit through after STARVE_LIMIT lost cycles. A per-register busy
// scoreboard reports pending long-latency destinations to decode.
// Optional feature: define RF_ARB_PERF_EN to add pipe_stall_cnt / long_full_cnt.
module rf_writeback_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LQ_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wr_valid,
  output logic            pipe_wr_ready,
  input  logic [4:0]      pipe_wr_addr,
  input  logic [XLEN-1:0] pipe_wr_data,
  input  logic            long_valid,
  output logic            long_ready,
  input  logic [4:0]      long_addr,
  input  logic [XLEN-1:0] long_data,
  input  logic            issue_mark,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_write,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
`ifdef RF_ARB_PERF_EN
  ,
  output logic [15:0]     pipe_stall_cnt,
  output logic [15:0]     long_full_cnt
`endif
);

  localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(LQ_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(LQ_DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(LQ_DEPTH - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]      r_q_addr [LQ_DEPTH];
  logic [XLEN-1:0] r_q_data [LQ_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic [31:0]     r_busy;
  logic            r_src_long;

  logic            w_empty;
  logic            w_full;
  logic            w_force;
  logic            w_grant_long;
  logic            w_pipe_xfer;
  logic            w_push;
  logic            w_grant_any;
  logic [4:0]      w_sel_addr;
  logic [XLEN-1:0] w_sel_data;
  logic [31:0]     w_busy_nxt;

  // Arbitration: pipeline first unless the FIFO head has starved long enough.
  always_comb begin
    w_empty       = (r_count == '0);
    w_full        = (r_count == FULL_CNT);
    w_force       = !w_empty && (r_starve == STARVE_MAX);
    w_grant_long  = !w_empty && (w_force || !pipe_wr_valid);
    pipe_wr_ready = !w_force;
    long_ready    = !w_full;
    w_pipe_xfer   = pipe_wr_valid && pipe_wr_ready;
    w_push        = long_valid && !w_full;
    w_grant_any   = w_grant_long || w_pipe_xfer;
    w_sel_addr    = w_grant_long ? r_q_addr[r_rd_ptr] : pipe_wr_addr;
    w_sel_data    = w_grant_long ? r_q_data[r_rd_ptr] : pipe_wr_data;
  end

  // FIFO storage; contents are don't-care until the occupancy count covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= long_addr;
      r_q_data[r_wr_ptr] <= long_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_grant_long)
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_grant_long})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter: counts cycles a waiting long result loses to the pipeline.
  always_ff @(posedge clk) begin
    if (rst)
      r_starve <= '0;
    else if (w_empty || w_grant_long)
      r_starve <= '0;
    else if (r_starve != STARVE_MAX)
      r_starve <= r_starve + 1'b1;
  end

  // Registered write port; x0 targets complete the handshake but never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write   <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      r_src_long <= 1'b0;
    end else begin
      rf_write   <= w_grant_any && (w_sel_addr != 5'd0);
      r_src_long <= w_grant_long;
      if (w_grant_any) begin
        rf_waddr <= w_sel_addr;
        rf_wdata <= w_sel_data;
      end
    end
  end

  // Scoreboard next state: clear on long-unit commit, then set on issue so set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rf_write && r_src_long)
      w_busy_nxt[rf_waddr] = 1'b0;
    if (issue_mark && (issue_rd != 5'd0))
      w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  // Decode hazard queries; no bypass of same-cycle commits.
  always_comb begin
    rs1_busy = r_busy[rs1_addr];
    rs2_busy = r_busy[rs2_addr];
  end

`ifdef RF_ARB_PERF_EN
  // Saturating performance counters for pipeline stalls and long-unit backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_stall_cnt <= '0;
      long_full_cnt  <= '0;
    end else begin
      if (pipe_wr_valid && !pipe_wr_ready && (pipe_stall_cnt != 16'hFFFF))
        pipe_stall_cnt <= pipe_stall_cnt + 1'b1;
      if (long_valid && w_full && (long_full_cnt != 16'hFFFF))
        long_full_cnt <= long_full_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Testbench for rf_writeback_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based behavioural model of the arbiter.
module tb_rf_writeback_arbiter;

  localparam int XLEN = 32;
  localparam int LQ   = 2;
  localparam int SL   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_wr_valid, pipe_wr_ready;
  logic [4:0]      pipe_wr_addr;
  logic [XLEN-1:0] pipe_wr_data;
  logic            long_valid, long_ready;
  logic [4:0]      long_addr;
  logic [XLEN-1:0] long_data;
  logic            issue_mark;
  logic [4:0]      issue_rd, rs1_addr, rs2_addr;
  logic            rs1_busy, rs2_busy;
  logic            rf_write;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
`ifdef RF_ARB_PERF_EN
  logic [15:0]     pipe_stall_cnt, long_full_cnt;
`endif

  rf_writeback_arbiter #(.XLEN(XLEN), .LQ_DEPTH(LQ), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_valid(pipe_wr_valid), .pipe_wr_ready(pipe_wr_ready),
    .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .long_valid(long_valid), .long_ready(long_ready),
    .long_addr(long_addr), .long_data(long_data),
    .issue_mark(issue_mark), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef RF_ARB_PERF_EN
    , .pipe_stall_cnt(pipe_stall_cnt), .long_full_cnt(long_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [4:0]  q_a[$];
  logic [31:0] q_d[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_wr, m_src;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_known = 0;

  // DUT combinational outputs sampled in the most recent cycle
  logic last_pready, last_lready, last_rs1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic im, input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
    bit ne, frc, gl, lrdy;
    logic [31:0] nb;
    rst = r; pipe_wr_valid = pv; pipe_wr_addr = pa; pipe_wr_data = pd;
    long_valid = lv; long_addr = la; long_data = ld;
    issue_mark = im; issue_rd = rd; rs1_addr = a1; rs2_addr = a2;
    @(negedge clk);
    ne   = q_a.size() > 0;
    frc  = ne && (m_starve == SL);
    gl   = ne && (frc || !pv);
    lrdy = q_a.size() < LQ;
    last_pready = pipe_wr_ready;
    last_lready = long_ready;
    last_rs1    = rs1_busy;
    if (m_known) begin
      check("pipe_wr_ready", pipe_wr_ready, !frc);
      check("long_ready", long_ready, lrdy);
      check("rs1_busy", rs1_busy, m_busy[a1]);
      check("rs2_busy", rs2_busy, m_busy[a2]);
    end
    @(posedge clk);
    #1;
    if (r) begin
      q_a.delete(); q_d.delete();
      m_starve = 0; m_busy = '0; m_wr = 0; m_src = 0; m_waddr = 0; m_wdata = 0;
      m_known = 1;
    end else if (m_known) begin
      nb = m_busy;
      if (m_wr && m_src) nb[m_waddr] = 1'b0;
      if (im && rd != 0) nb[rd] = 1'b1;
      m_busy = nb;
      if (gl) begin
        m_wr = (q_a[0] != 0); m_waddr = q_a[0]; m_wdata = q_d[0]; m_src = 1;
        void'(q_a.pop_front()); void'(q_d.pop_front());
      end else if (pv) begin
        m_wr = (pa != 0); m_waddr = pa; m_wdata = pd; m_src = 0;
      end else begin
        m_wr = 0; m_src = 0;
      end
      if (lv && lrdy) begin q_a.push_back(la); q_d.push_back(ld); end
      m_starve = (!ne || gl) ? 0 : ((m_starve < SL) ? m_starve + 1 : SL);
    end
    if (m_known) begin
      check("rf_write", rf_write, m_wr);
      if (m_wr) begin
        check("rf_waddr", rf_waddr, m_waddr);
        check("rf_wdata", rf_wdata, m_wdata);
      end
    end
  endtask

  initial begin
    // 1 Reset with valids high, then sweep the scoreboard
    cycle(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 1, 5'd6, 5'd6, 5'd4);
    cycle(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 1, 5'd6, 5'd6, 5'd4);
    check("rst_rf_write", rf_write, 0);
    check("rst_long_ready", last_lready, 1);
    for (int i = 0; i < 16; i++)
      cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'(2 * i), 5'(2 * i + 1));

    // 2 Pipe only
    cycle(0, 1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t2_write", rf_write, 1);
    check("t2_addr", rf_waddr, 5);
    check("t2_data", rf_wdata, 32'hA5A5A5A5);

    // 3 Contention: long x7 forced through after four lost cycles
    cycle(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
      check("t3_ready_pre", last_pready, 1);
    end
    cycle(0, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t3_ready_forced", last_pready, 0);
    check("t3_waddr", rf_waddr, 7);
    check("t3_wdata", rf_wdata, 32'h77);
    cycle(0, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t3_pipe_after", rf_waddr, 3);

    // 4 Scoreboard on x9, including same-edge re-issue during commit
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0);
    check("t4_busy_before", last_rs1, 0);
    cycle(0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 5'd0, 5'd9, 5'd0);
    check("t4_busy_set", last_rs1, 1);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
    check("t4_commit_addr", rf_waddr, 9);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0);
    check("t4_busy_commit", last_rs1, 1);
    cycle(0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h999, 0, 5'd0, 5'd9, 5'd0);
    check("t4_set_wins", last_rs1, 1);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
    check("t4_busy_last", last_rs1, 1);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
    check("t4_busy_clear", last_rs1, 0);

    // 5 FIFO full with pipe saturating, then drain
    cycle(0, 1, 5'd1, 32'h11, 1, 5'd10, 32'hA0, 0, 5'd0, 5'd0, 5'd0);
    cycle(0, 1, 5'd1, 32'h11, 1, 5'd11, 32'hB0, 0, 5'd0, 5'd0, 5'd0);
    cycle(0, 1, 5'd1, 32'h11, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t5_full", last_lready, 0);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t5_pop_addr", rf_waddr, 10);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t5_not_full", last_lready, 1);

    // 6 x0 writes from both sources and x0 issue
    cycle(0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t6_pipe_x0", rf_write, 0);
    check("t6_pipe_ready", last_pready, 1);
    cycle(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hBEEF, 1, 5'd0, 5'd0, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t6_long_x0", rf_write, 0);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    check("t6_busy0", last_rs1, 0);
    check("t6_drained", last_lready, 1);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 7, 5'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 4) == 0, 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
